// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle between the control unit and div_seq.
// master = control unit, slave = divider.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             DivCtrl;
  logic             DivSigned;
  logic [WIDTH-1:0] RegAOut;
  logic [WIDTH-1:0] RegBOut;
  logic             DivBusy;
  logic             DivDone;
  logic             Div0;
  logic [WIDTH-1:0] DivHIOut;
  logic [WIDTH-1:0] DivLOOut;

  modport master (
    output DivCtrl, DivSigned, RegAOut, RegBOut,
    input  DivBusy, DivDone, Div0, DivHIOut, DivLOOut
  );

  modport slave (
    input  DivCtrl, DivSigned, RegAOut, RegBOut,
    output DivBusy, DivDone, Div0, DivHIOut, DivLOOut
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring signed/unsigned divider, LO=quotient HI=remainder.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  div_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sh;
  logic             ge;

  // Operand magnitudes at the start edge
  always_comb begin
    sa    = bus.DivSigned & bus.RegAOut[WIDTH-1];
    sb    = bus.DivSigned & bus.RegBOut[WIDTH-1];
    mag_a = sa ? -bus.RegAOut : bus.RegAOut;
    mag_b = sb ? -bus.RegBOut : bus.RegBOut;
  end

  // One restoring step: shift in next dividend bit, try to subtract
  always_comb begin
    sh = {r_q, a_q[WIDTH-1]};
    ge = sh >= {1'b0, b_q};
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.DivCtrl) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d  = 1'b0;
          sign_a_d = sa;
          sign_b_d = sb;
          a_d      = mag_a;
          b_d      = mag_b;
          r_d      = '0;
          cnt_d    = CW'(WIDTH);
          busy_d   = 1'b1;
          div0_d   = 1'b0;
          hi_d     = '0;
          lo_d     = '0;
          if (mag_b == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            div0_d  = 1'b1;
            lo_d    = '1;
            hi_d    = bus.RegAOut;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (mag_a < mag_b) begin
            state_d = FIX;
            a_d     = '0;
            r_d     = mag_a;
          end
`endif
          else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = ge ? sh[WIDTH-1:0] - b_q : sh[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
        hi_d    = sign_a_q ? -r_q : r_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      armed_q  <= 1'b1;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.DivBusy  = busy_q;
  assign bus.DivDone  = done_q;
  assign bus.Div0     = div0_q;
  assign bus.DivHIOut = hi_q;
  assign bus.DivLOOut = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq (WIDTH=32).
// Latency expectations follow DIV_EARLY_OUT_EN when it is defined.
module tb_div_seq;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  // Start one op, drop DivCtrl and scramble operands at cycle 2.
  // Cycle k is sampled at the negedge after edge k-1.
  task automatic do_op(
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          dcyc,
    output int          nd
  );
    @(negedge clk);
    bus.DivSigned = sgn;
    bus.RegAOut   = a;
    bus.RegBOut   = b;
    bus.DivCtrl   = 1'b1;
    dcyc = 0;
    nd   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.DivDone) begin
        nd++;
        if (dcyc == 0) dcyc = k;
      end
      if (k == 2) begin
        bus.DivCtrl   = 1'b0;
        bus.RegAOut   = ~a;
        bus.RegBOut   = b + 32'd1;
        bus.DivSigned = ~sgn;
      end
    end
  endtask

  task automatic chk_res(
    input string       nm,
    input logic [31:0] lo,
    input logic [31:0] hi,
    input logic        d0,
    input int          dcyc,
    input int          nd,
    input int          lat
  );
    total++;
    if (bus.DivLOOut !== lo)
      $display("FAIL %s LO got %h want %h", nm, bus.DivLOOut, lo);
    else passed++;
    total++;
    if (bus.DivHIOut !== hi)
      $display("FAIL %s HI got %h want %h", nm, bus.DivHIOut, hi);
    else passed++;
    total++;
    if (bus.Div0 !== d0)
      $display("FAIL %s Div0 got %b want %b", nm, bus.Div0, d0);
    else passed++;
    total++;
    if (dcyc !== lat)
      $display("FAIL %s done_cycle got %0d want %0d", nm, dcyc, lat);
    else passed++;
    total++;
    if (nd !== 1)
      $display("FAIL %s done_count got %0d want 1", nm, nd);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.DivCtrl   = 1'b0;
    bus.DivSigned = 1'b0;
    bus.RegAOut   = '0;
    bus.RegBOut   = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.DivBusy, bus.DivDone, bus.Div0} !== 3'b000)
      $display("FAIL reset_flags got %b want 000",
               {bus.DivBusy, bus.DivDone, bus.Div0});
    else passed++;
    total++;
    if ({bus.DivHIOut, bus.DivLOOut} !== 64'd0)
      $display("FAIL reset_hilo got %h want 0",
               {bus.DivHIOut, bus.DivLOOut});
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_signed;
    int dc, nd;
    do_op(1'b1, 32'd7, 32'hFFFF_FFFD, dc, nd);
    chk_res("s7_m3", 32'hFFFF_FFFE, 32'd1, 1'b0, dc, nd, 34);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd3, dc, nd);
    chk_res("sm7_3", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, dc, nd, 34);
  endtask

  task automatic test_unsigned;
    int dc, nd;
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, dc, nd);
    chk_res("u_ff_2", 32'h7FFF_FFFF, 32'd1, 1'b0, dc, nd, 34);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd2, dc, nd);
    chk_res("s_m1_2", 32'd0, 32'hFFFF_FFFF, 1'b0, dc, nd,
            EARLY ? 2 : 34);
  endtask

  task automatic test_div0;
    int dc, nd;
    do_op(1'b0, 32'h1234_5678, 32'd0, dc, nd);
    chk_res("div0", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, dc, nd, 1);
    do_op(1'b0, 32'd100, 32'd7, dc, nd);
    chk_res("after_div0", 32'd14, 32'd2, 1'b0, dc, nd, 34);
  endtask

  task automatic test_min;
    int dc, nd;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, dc, nd);
    chk_res("min_m1", 32'h8000_0000, 32'd0, 1'b0, dc, nd, 34);
  endtask

  task automatic test_hold;
    int nd, dc;
    @(negedge clk);
    bus.DivSigned = 1'b0;
    bus.RegAOut   = 32'd20;
    bus.RegBOut   = 32'd6;
    bus.DivCtrl   = 1'b1;
    nd = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.DivDone) nd++;
    end
    total++;
    if (nd !== 1)
      $display("FAIL hold_done_count got %0d want 1", nd);
    else passed++;
    total++;
    if (bus.DivLOOut !== 32'd3 || bus.DivHIOut !== 32'd2)
      $display("FAIL hold_result got %h/%h want 3/2",
               bus.DivLOOut, bus.DivHIOut);
    else passed++;
    bus.DivCtrl = 1'b0;
    @(negedge clk);
    bus.RegAOut = 32'd45;
    bus.RegBOut = 32'd7;
    bus.DivCtrl = 1'b1;
    nd = 0;
    dc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.DivDone) begin
        nd++;
        if (dc == 0) dc = k;
      end
    end
    bus.DivCtrl = 1'b0;
    chk_res("rearm", 32'd6, 32'd3, 1'b0, dc, nd, 34);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dc, nd;
    @(negedge clk);
    bus.DivSigned = 1'b0;
    bus.RegAOut   = 32'd100;
    bus.RegBOut   = 32'd7;
    bus.DivCtrl   = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 2) bus.DivCtrl = 1'b0;
    end
    total++;
    if (bus.DivBusy !== 1'b1)
      $display("FAIL mid_busy got %b want 1", bus.DivBusy);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.DivBusy, bus.DivDone, bus.Div0, bus.DivHIOut,
         bus.DivLOOut} !== 67'd0)
      $display("FAIL mid_reset_out got %b%b%b %h %h want all 0",
               bus.DivBusy, bus.DivDone, bus.Div0,
               bus.DivHIOut, bus.DivLOOut);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.DivDone) nd++;
    end
    total++;
    if (nd !== 0)
      $display("FAIL mid_no_done got %0d want 0", nd);
    else passed++;
    do_op(1'b0, 32'd100, 32'd7, dc, nd);
    chk_res("post_reset", 32'd14, 32'd2, 1'b0, dc, nd, 34);
  endtask

  task automatic test_early;
    int dc, nd;
    do_op(1'b0, 32'd3, 32'd7, dc, nd);
    chk_res("u3_7", 32'd0, 32'd3, 1'b0, dc, nd, EARLY ? 2 : 34);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_signed();
    test_unsigned();
    test_div0();
    test_min();
    test_hold();
    test_reset_mid();
    test_early();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised sequential integer divider for the datapath's HI/LO unit. It replaces the repeated-subtraction divider with a radix-2 restoring shift-subtract core that has fixed latency in WIDTH. It supports signed and unsigned division selected per operation, and presents the quotient on LO and the remainder on HI. It is started and sequenced by the control unit through a level request with one-cycle completion strobe.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- DivCtrl  in  1  start request (level); an operation starts only on a 0→1 qualified edge (see Operation).
- DivSigned  in  1  1 = two's-complement divide, 0 = unsigned; sampled at start.
- RegAOut  in  WIDTH  dividend; sampled at start.
- RegBOut  in  WIDTH  divisor; sampled at start.
- DivBusy  out  1  high from the start edge until DivDone is asserted.
- DivDone  out  1  one-cycle completion strobe.
- Div0  out  1  divisor was zero; held until next start.
- DivHIOut  out  WIDTH  remainder; held until next start.
- DivLOOut  out  WIDTH  quotient; held until next start.

## Operation
- States: IDLE, RUN, FIX, DONE.
- The armed flag is set by reset and set whenever DivCtrl is sampled 0 in IDLE.
- Start occurs when the state is IDLE, armed=1 and DivCtrl=1 on an edge.
- On start:
  - Latch sign flags: signA = DivSigned & RegAOut[MSB], signB = DivSigned & RegBOut[MSB].
  - Latch WIDTH-bit unsigned magnitudes (two's-complement negate when the sign flag is set).
  - Clear armed, Div0, HI and LO.
  - Set step counter = WIDTH.
- On start with divisor == 0: go to DONE. Set Div0=1, LO = all ones, HI = RegAOut unmodified.
- RUN: each cycle, shift the partial remainder left by one and bring in the next dividend bit (MSB first).
  - If partial remainder ≥ |divisor|: subtract and set the quotient bit to 1; otherwise set it to 0.
  - Decrement the counter. Go to FIX after WIDTH steps.
- FIX:
  - Quotient = negate(q) if signA ^ signB, else q.
  - Remainder = negate(r) if signA, else r (truncating division; remainder takes the dividend's sign).
  - Register both into LO/HI and go to DONE.
- DONE: DivDone=1 for one cycle, then return to IDLE. Outputs hold.
- Signed MIN / -1: quotient = MIN (wraps), remainder 0, Div0=0.
- DivCtrl deasserting mid-operation does not abort; the result completes normally.
- DivCtrl held high through DONE does not restart; it must be seen low in IDLE first.
- DivSigned, RegAOut and RegBOut changes after start are ignored.

## Timing
- Edge 0 = start edge. RUN occupies edges 1..WIDTH. Edge WIDTH+1 is FIX→DONE, and results are valid from then on. DivDone is high for exactly the cycle following edge WIDTH+1. Total latency is WIDTH+2 cycles (34 for WIDTH=32).
- Divide-by-zero: DONE is entered at edge 0, and DivDone/Div0 are high in the cycle following edge 0.
- DivBusy is high from edge 0 through the DivDone cycle inclusive.
- Reset values (asynchronous):
  - State IDLE, armed=1.
  - DivBusy=0, DivDone=0, Div0=0.
  - DivHIOut=0, DivLOOut=0.
  - Internal magnitudes, counter and sign flags zero.
- Reset mid-operation discards the operation immediately; no DivDone is produced.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - At start with nonzero divisor and |dividend| < |divisor| (unsigned magnitudes), go straight to FIX with q=0 and r=|dividend|.
  - DivDone appears in the cycle following edge 1 (2-cycle latency).
  - Sign correction applies as normal.
- Undefined: every nonzero-divisor operation takes exactly WIDTH+2 cycles, with no data-dependent latency.

## Test plan
- WIDTH=32, signed, 7 / -3 → LO=0xFFFFFFFE, HI=1, Div0=0, DivDone only in cycle 34 after start.
- Unsigned, 0xFFFFFFFF / 2 → LO=0x7FFFFFFF, HI=1. The same operands signed (-1 / 2) → LO=0, HI=0xFFFFFFFF.
- Divisor 0, dividend 0x12345678 → Div0=1, LO=0xFFFFFFFF, HI=0x12345678, DivDone in cycle 1. The next start clears Div0.
- Signed 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, Div0=0. Also -7 / 3 → LO=0xFFFFFFFE, HI=0xFFFFFFFF.
- DivCtrl held high for 100 cycles → exactly one DivDone. Lower DivCtrl for 1 cycle, raise it again → second operation. Assert reset at RUN step 10 → all outputs 0, no DivDone, next start behaves normally.
- With DIV_EARLY_OUT_EN, unsigned 3 / 7 → LO=0, HI=3, DivDone in cycle 2. Without the macro → same values in cycle 34.
